// File: rtl/mm_mult_arbiter_if.sv
// mm_mult_arbiter_if: requester and multiplier bundle for the arbiter.
// Also hosts the shared operand/product width package.
package bit_width;
  localparam int INWIDTH = 16;
  localparam int OUTWIDTH = 32;
endpackage

interface mm_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int WI = bit_width::INWIDTH;
  localparam int WO = bit_width::OUTWIDTH;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*WI-1:0] req_a;
  logic [NUM_REQ*WI-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [WO-1:0]         rsp_product;
  logic                  rsp_err;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic                  mult_start;
  logic [WI-1:0]         mult_a;
  logic [WI-1:0]         mult_b;
  logic                  mult_done;
  logic [WO-1:0]         mult_product;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b,
    input  rsp_ready,
    input  mult_done, mult_product,
    output req_ready, rsp_valid,
    output rsp_product, rsp_err,
    output mult_start, mult_a, mult_b,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b,
    output rsp_ready,
    output mult_done, mult_product,
    input  req_ready, rsp_valid,
    input  rsp_product, rsp_err,
    input  mult_start, mult_a, mult_b,
    input  busy
  );
endinterface

// File: rtl/mm_mult_arbiter.sv
// mm_mult_arbiter: round-robin sharing of one multiplier
// between NUM_REQ requesters, with a completion timeout.
module mm_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset_n,
  mm_mult_arbiter_if.slave bus
);
  localparam int WI = bit_width::INWIDTH;
  localparam int WO = bit_width::OUTWIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [WI-1:0]      a_q;
  logic [WI-1:0]      b_q;
  logic [WO-1:0]      prod_q;
  logic               err_q;
  logic               start_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic               found_d;
  logic [IW-1:0]      win_d;
  logic [IW-1:0]      cand_d;
  logic [WI-1:0]      sel_a_d;
  logic [WI-1:0]      sel_b_d;
  logic               rsp_hit_d;
  logic               tmo_d;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [IW-1:0] idx
  );
    logic [NUM_REQ-1:0] o;
    o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o[i] = (idx == IW'(i));
    end
    return o;
  endfunction

  // Round-robin search starting just after the last granted index
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    cand_d  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_d = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found_d &&
          |(bus.req_valid & onehot(cand_d))) begin
        found_d = 1'b1;
        win_d   = cand_d;
      end
    end
  end

  // Operand mux for the current winner
  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == IW'(i)) begin
        sel_a_d = bus.req_a[i*WI +: WI];
        sel_b_d = bus.req_b[i*WI +: WI];
      end
    end
  end

  // Only the owner's rsp_ready can complete the response
  assign rsp_hit_d = |(bus.rsp_ready & rsp_valid_q);
  assign tmo_d     = (cnt_q == CW'(TIMEOUT - 1));

  // Arbitration / multiplier sequencing FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      idx_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            a_q     <= sel_a_d;
            b_q     <= sel_b_d;
            idx_q   <= win_d;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.mult_done) begin
            prod_q      <= bus.mult_product;
            err_q       <= 1'b0;
            rsp_valid_q <= onehot(idx_q);
            state_q     <= RESP;
          end else if (tmo_d) begin
            prod_q      <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= onehot(idx_q);
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_hit_d) begin
            last_q      <= idx_q;
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  // Grant is combinational, and forced off while in reset
  assign bus.req_ready =
    (state_q == IDLE && reset_n && found_d) ?
    onehot(win_d) : '0;

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err     = err_q;
  assign bus.mult_start  = start_q;
  assign bus.mult_a      = a_q;
  assign bus.mult_b      = b_q;
  assign bus.busy        = (state_q != IDLE);

  // Per-requester strobes are never shared
  a_ready_oh: assert property (
    @(posedge clk) disable iff (!reset_n)
    $onehot0(bus.req_ready));
  a_rsp_oh: assert property (
    @(posedge clk) disable iff (!reset_n)
    $onehot0(bus.rsp_valid));
endmodule

// File: tb/tb_mm_mult_arbiter.sv
// tb_mm_mult_arbiter: randomized bench with a round-robin
// reference and a behavioural multiplier.
module tb_mm_mult_arbiter;
  localparam int N  = 4;
  localparam int TO = 64;
  localparam int WI = 16;
  localparam int WO = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_last;

  logic [WI-1:0] ra [N];
  logic [WI-1:0] rb [N];

  logic man_done = 1'b0;
  logic mdl_done = 1'b0;
  logic [WO-1:0] man_prod = '0;
  logic [WO-1:0] mdl_prod = '0;
  int mult_lat = 4;
  bit mult_never = 1'b0;

  mm_mult_arbiter_if #(.NUM_REQ(N)) bus ();

  mm_mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  assign bus.mult_done    = man_done | mdl_done;
  assign bus.mult_product = man_done ? man_prod : mdl_prod;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: signed product after mult_lat cycles
  initial begin : mult_model
    int pa;
    int pb;
    forever begin
      @(negedge clk);
      if (bus.mult_start === 1'b1 && !mult_never) begin
        pa = $signed(bus.mult_a);
        pb = $signed(bus.mult_b);
        repeat (mult_lat) @(posedge clk);
        #1;
        mdl_prod = pa * pb;
        mdl_done = 1'b1;
        @(posedge clk);
        #1;
        mdl_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input int last,
                                 input logic [N-1:0] v);
    logic [N-1:0] sh;
    int idx;
    rr_pick = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      sh = v >> idx;
      if (rr_pick < 0 && sh[0]) rr_pick = idx;
    end
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    oh = (i < 0) ? '0 : (N'(1) << i);
  endfunction

  function automatic logic [WO-1:0] sprod(input logic [WI-1:0] a,
                                          input logic [WI-1:0] b);
    int pa;
    int pb;
    pa = $signed(a);
    pb = $signed(b);
    sprod = pa * pb;
  endfunction

  function automatic logic [WI-1:0] pick_op();
    case ($urandom_range(0, 5))
      0: pick_op = 16'h8000;
      1: pick_op = 16'h7FFF;
      2: pick_op = 16'hFFFF;
      3: pick_op = 16'h0000;
      default: pick_op = 16'($urandom);
    endcase
  endfunction

  task automatic drive_ops();
    bus.req_a = {ra[3], ra[2], ra[1], ra[0]};
    bus.req_b = {rb[3], rb[2], rb[1], rb[0]};
  endtask

  task automatic new_ops();
    for (int i = 0; i < N; i++) begin
      ra[i] = pick_op();
      rb[i] = pick_op();
    end
    drive_ops();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    new_ops();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== '0) begin
      failures++;
      $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.mult_start !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_start got=%b%b exp=00",
               bus.busy, bus.mult_start);
    end
    checks++;
    if (bus.mult_a !== '0 || bus.mult_b !== '0) begin
      failures++;
      $display("FAIL rst_mult_ab got=%h/%h exp=0/0",
               bus.mult_a, bus.mult_b);
    end
    checks++;
    if (bus.rsp_valid !== '0 || bus.rsp_product !== '0 ||
        bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_rsp got=%b/%h/%b exp=0/0/0",
               bus.rsp_valid, bus.rsp_product, bus.rsp_err);
    end
    bus.req_valid = '0;
    reset_n = 1'b1;
    m_last = N - 1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    int t0;
    int n;
    ra[2] = 16'd3;
    rb[2] = 16'hFFFB;
    drive_ops();
    mult_lat = 8;
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant got=%b exp=0100", bus.req_ready);
    end
    t0 = cyc;
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if (bus.mult_start !== 1'b1 || bus.mult_a !== 16'd3 ||
        bus.mult_b !== 16'hFFFB) begin
      failures++;
      $display("FAIL single_start got=%b %h %h exp=1 0003 fffb",
               bus.mult_start, bus.mult_a, bus.mult_b);
    end
    n = 0;
    while (bus.rsp_valid === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - t0 != 10) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=10", cyc - t0);
    end
    checks++;
    if (bus.rsp_valid !== 4'b0100 ||
        bus.rsp_product !== 32'hFFFFFFF1 ||
        bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got=%b %h %b exp=0100 fffffff1 0",
               bus.rsp_valid, bus.rsp_product, bus.rsp_err);
    end
    bus.rsp_ready = 4'b0100;
    @(negedge clk);
    bus.rsp_ready = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
      failures++;
      $display("FAIL single_release got=%b %b exp=0 0000",
               bus.busy, bus.rsp_valid);
    end
    m_last = 2;
  endtask

  task automatic test_round_robin();
    int ord [5] = '{0, 1, 2, 3, 0};
    int seen [$];
    int w;
    int obs;
    int n;
    bit dup;
    logic [N-1:0] sh;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_last = N - 1;
    new_ops();
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    for (int g = 0; g < 8; g++) begin
      mult_lat = $urandom_range(1, 6);
      #1;
      w = rr_pick(m_last, bus.req_valid);
      obs = -1;
      for (int j = 0; j < N; j++) begin
        sh = bus.req_ready >> j;
        if (sh[0]) obs = j;
      end
      checks++;
      if (bus.req_ready !== oh(w)) begin
        failures++;
        $display("FAIL rr_grant[%0d] got=%b exp=%b",
                 g, bus.req_ready, oh(w));
      end
      if (g < 5) begin
        checks++;
        if (obs != ord[g]) begin
          failures++;
          $display("FAIL rr_order[%0d] got=%0d exp=%0d",
                   g, obs, ord[g]);
        end
      end
      seen.push_back(obs);
      if (seen.size() >= 4) begin
        dup = 1'b0;
        for (int a = seen.size() - 4; a < seen.size(); a++)
          for (int b = a + 1; b < seen.size(); b++)
            if (seen[a] == seen[b]) dup = 1'b1;
        checks++;
        if (dup) begin
          failures++;
          $display("FAIL rr_window[%0d] got=repeat exp=distinct", g);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.mult_a !== ra[w] || bus.mult_b !== rb[w]) begin
        failures++;
        $display("FAIL rr_ops[%0d] got=%h %h exp=%h %h",
                 g, bus.mult_a, bus.mult_b, ra[w], rb[w]);
      end
      n = 0;
      while (bus.rsp_valid === '0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.rsp_valid !== oh(w) ||
          bus.rsp_product !== sprod(ra[w], rb[w]) ||
          bus.rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL rr_rsp[%0d] got=%b %h %b exp=%b %h 0", g,
                 bus.rsp_valid, bus.rsp_product, bus.rsp_err,
                 oh(w), sprod(ra[w], rb[w]));
      end
      m_last = w;
      new_ops();
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [WO-1:0] p;
    int w;
    int t0;
    int n;
    int d;
    for (int it = 0; it < 40; it++) begin
      mult_lat = $urandom_range(1, 12);
      v = N'($urandom);
      if ($urandom_range(0, 4) == 0) v = '0;
      new_ops();
      bus.req_valid = v;
      #1;
      w = rr_pick(m_last, v);
      checks++;
      if (bus.req_ready !== oh(w)) begin
        failures++;
        $display("FAIL rnd_grant[%0d] got=%b exp=%b",
                 it, bus.req_ready, oh(w));
      end
      if (w < 0) begin
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
          failures++;
          $display("FAIL rnd_idle[%0d] got=%b %b exp=0 0000",
                   it, bus.busy, bus.rsp_valid);
        end
        continue;
      end
      t0 = cyc;
      @(negedge clk);
      bus.req_valid = N'($urandom);
      checks++;
      if (bus.mult_start !== 1'b1 || bus.mult_a !== ra[w] ||
          bus.mult_b !== rb[w]) begin
        failures++;
        $display("FAIL rnd_start[%0d] got=%b %h %h exp=1 %h %h", it,
                 bus.mult_start, bus.mult_a, bus.mult_b, ra[w], rb[w]);
      end
      n = 0;
      while (bus.rsp_valid === '0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      p = sprod(ra[w], rb[w]);
      checks++;
      if (cyc - t0 != mult_lat + 2 || bus.rsp_valid !== oh(w) ||
          bus.rsp_product !== p || bus.rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL rnd_rsp[%0d] got=%0d %b %h %b exp=%0d %b %h 0",
                 it, cyc - t0, bus.rsp_valid, bus.rsp_product,
                 bus.rsp_err, mult_lat + 2, oh(w), p);
      end
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        bus.rsp_ready = N'($urandom) & ~oh(w);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== oh(w) || bus.rsp_product !== p) begin
          failures++;
          $display("FAIL rnd_hold[%0d] got=%b %h exp=%b %h",
                   it, bus.rsp_valid, bus.rsp_product, oh(w), p);
        end
      end
      bus.rsp_ready = oh(w) | N'($urandom);
      @(negedge clk);
      bus.rsp_ready = '0;
      checks++;
      if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL rnd_release[%0d] got=%b %b exp=0000 0",
                 it, bus.rsp_valid, bus.busy);
      end
      m_last = w;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [WO-1:0] p;
    int n;
    new_ops();
    mult_lat = 3;
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '1;
    n = 0;
    while (bus.rsp_valid === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    p = sprod(ra[1], rb[1]);
    for (int k = 0; k < 20; k++) begin
      bus.rsp_ready = N'($urandom) & 4'b1101;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 4'b0010 || bus.rsp_product !== p ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b %h %b %b exp=0010 %h 0 0000",
                 k, bus.rsp_valid, bus.rsp_product, bus.rsp_err,
                 bus.req_ready, p);
      end
    end
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    bus.rsp_ready = '0;
    m_last = 1;
    checks++;
    if (bus.req_ready !== oh(rr_pick(m_last, 4'b1111))) begin
      failures++;
      $display("FAIL bp_next_grant got=%b exp=%b",
               bus.req_ready, oh(rr_pick(m_last, 4'b1111)));
    end
    bus.req_valid = '0;
  endtask

  task automatic test_timeout();
    int t0;
    mult_never = 1'b1;
    new_ops();
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL tmo_grant got=%b exp=0001", bus.req_ready);
    end
    t0 = cyc;
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if (bus.mult_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_start got=%b exp=1", bus.mult_start);
    end
    for (int k = 2; k < TO + 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== '0 || bus.busy !== 1'b1 ||
          bus.mult_a !== ra[0] || bus.mult_b !== rb[0]) begin
        failures++;
        $display("FAIL tmo_wait[%0d] got=%b %b %h exp=0000 1 %h",
                 k, bus.rsp_valid, bus.busy, bus.mult_a, ra[0]);
      end
    end
    @(negedge clk);
    checks++;
    if (cyc - t0 != TO + 2 || bus.rsp_valid !== 4'b0001 ||
        bus.rsp_product !== '0 || bus.rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_rsp got=%0d %b %h %b exp=%0d 0001 0 1",
               cyc - t0, bus.rsp_valid, bus.rsp_product,
               bus.rsp_err, TO + 2);
    end
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    bus.rsp_ready = '0;
    m_last = 0;
    mult_never = 1'b0;
  endtask

  task automatic test_spurious();
    mult_never = 1'b1;
    bus.req_valid = '0;
    man_prod = 32'hDEADBEEF;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
      failures++;
      $display("FAIL spur_idle got=%b %b exp=0 0000",
               bus.busy, bus.rsp_valid);
    end
    new_ops();
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL spur_grant got=%b exp=0001", bus.req_ready);
    end
    @(posedge clk);
    #1;
    man_done = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if (bus.mult_start !== 1'b1) begin
      failures++;
      $display("FAIL spur_start got=%b exp=1", bus.mult_start);
    end
    @(posedge clk);
    #1;
    man_done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== '0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL spur_start_ignored got=%b %b exp=0000 1",
               bus.rsp_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== '0) begin
      failures++;
      $display("FAIL spur_wait got=%b exp=0000", bus.rsp_valid);
    end
    man_prod = 32'h12345678;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (bus.rsp_valid !== 4'b0001 ||
        bus.rsp_product !== 32'h12345678 ||
        bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL spur_rsp got=%b %h %b exp=0001 12345678 0",
               bus.rsp_valid, bus.rsp_product, bus.rsp_err);
    end
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    bus.rsp_ready = '0;
    m_last = 0;
    mult_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    new_ops();
    mult_lat = 4;
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL rmid_pre_grant got=%b exp=0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_product !== sprod(ra[1], rb[1])) begin
      failures++;
      $display("FAIL rmid_pre_rsp got=%h exp=%h",
               bus.rsp_product, sprod(ra[1], rb[1]));
    end
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    bus.rsp_ready = '0;
    m_last = 1;
    mult_lat = 20;
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rmid_grant got=%b exp=0100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    bus.req_valid = 4'b1110;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== '0 ||
        bus.mult_start !== 1'b0) begin
      failures++;
      $display("FAIL rmid_ctrl got=%b %b %b exp=0 0000 0",
               bus.busy, bus.req_ready, bus.mult_start);
    end
    checks++;
    if (bus.mult_a !== '0 || bus.mult_b !== '0 ||
        bus.rsp_valid !== '0 || bus.rsp_product !== '0 ||
        bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_data got=%h %h %b %h %b exp=0",
               bus.mult_a, bus.mult_b, bus.rsp_valid,
               bus.rsp_product, bus.rsp_err);
    end
    @(negedge clk);
    bus.req_valid = '0;
    reset_n = 1'b1;
    m_last = N - 1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
        failures++;
        $display("FAIL rmid_stale[%0d] got=%b %b exp=0 0000",
                 k, bus.busy, bus.rsp_valid);
      end
    end
    mult_lat = 2;
    bus.req_valid = 4'b1110;
    #1;
    checks++;
    if (bus.req_ready !== oh(rr_pick(m_last, 4'b1110))) begin
      failures++;
      $display("FAIL rmid_next_grant got=%b exp=%b",
               bus.req_ready, oh(rr_pick(m_last, 4'b1110)));
    end
    @(negedge clk);
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 4'b0010 ||
        bus.rsp_product !== sprod(ra[1], rb[1])) begin
      failures++;
      $display("FAIL rmid_next_rsp got=%b %h exp=0010 %h",
               bus.rsp_valid, bus.rsp_product, sprod(ra[1], rb[1]));
    end
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    bus.rsp_ready = '0;
    m_last = 1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_random();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mm_mult_arbiter.md
MM_MULT_ARBITER -- requirements
Module: mm_mult_arbiter

Interface
REQ-001 The block SHALL have a parameter NUM_REQ, default 4, setting the number of requesters sharing one multiplier (range 2..8).
REQ-002 The block SHALL have a parameter TIMEOUT, default 64, setting the maximum number of cycles it waits for mult_done.
REQ-003 Operand width SHALL be bit_width::INWIDTH (16) and product width SHALL be bit_width::OUTWIDTH (32).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operand-pair valid.
REQ-007 req_a, req_b  in  NUM_REQ*INWIDTH  packed operands; requester i occupies bits [i*INWIDTH +: INWIDTH].
REQ-008 req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-009 rsp_valid  out  NUM_REQ  per-requester result valid; at most one bit high.
REQ-010 rsp_product  out  OUTWIDTH  shared result bus.
REQ-011 rsp_err  out  1  qualifies rsp_valid; high means the result timed out.
REQ-012 rsp_ready  in  NUM_REQ  per-requester result accept.
REQ-013 mult_start  out  1  one-cycle start pulse to the shared multiplier.
REQ-014 mult_a, mult_b  out  INWIDTH  multiplier operands.
REQ-015 mult_done  in  1  one-cycle completion pulse from the multiplier.
REQ-016 mult_product  in  OUTWIDTH  multiplier result, valid while mult_done is high.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, START, WAIT and RESP.
REQ-019 In IDLE, req_ready SHALL be asserted combinationally only for the round-robin winner.
- Winner = first requester with req_valid high, searching from last_grant+1 upward, with wrap-around modulo NUM_REQ.
- No req_valid high: req_ready is all zero and the FSM stays in IDLE.
REQ-020 On the handshake (req_valid[w] and req_ready[w]), the block SHALL capture req_a[w], req_b[w] and index w, then move to START.
REQ-021 In START, mult_start SHALL be high for exactly one cycle, with mult_a/mult_b equal to the captured operands; the FSM then moves to WAIT.
REQ-022 mult_a/mult_b SHALL hold the captured operands from START until the FSM leaves WAIT.
REQ-023 In WAIT, when mult_done is high, the block SHALL capture mult_product, clear the error flag and move to RESP.
REQ-024 In WAIT, when TIMEOUT cycles elapse without mult_done, the block SHALL load product 0, set the error flag and move to RESP.
- The timeout counter is 0 on entry to WAIT and increments each cycle.
- Timeout fires on the cycle the counter equals TIMEOUT-1.
REQ-025 mult_done SHALL be ignored in IDLE, START and RESP.
REQ-026 In RESP, rsp_valid[w] SHALL be high, and rsp_product and rsp_err SHALL hold steady until rsp_ready[w] is high.
- rsp_ready on any other index is ignored.
REQ-027 On the RESP handshake, the block SHALL set last_grant to w and move to IDLE; a new grant is possible in the next cycle.
REQ-028 Timing: a grant accepted in cycle T SHALL produce mult_start in T+1; mult_done in cycle D SHALL produce rsp_valid in D+1.
REQ-029 Round-robin SHALL guarantee that a continuously valid requester is granted within NUM_REQ grants.
REQ-030 If a requester drops req_valid while not granted, the block SHALL keep no state for that requester.

Reset
REQ-031 While reset_n is low, the block SHALL immediately force:
- state IDLE;
- last_grant = NUM_REQ-1, so requester 0 wins first;
- req_ready, rsp_valid, mult_start, busy, rsp_err all 0;
- mult_a, mult_b, rsp_product all 0;
- timeout counter 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation, and the block SHALL then ignore any later mult_done for the aborted operation.

Verification
REQ-033 Single op: req 2 sends a=3, b=-5, multiplier done 8 cycles after start -> rsp_valid[2] with product 0xFFFFFFF1, rsp_err=0, 10 cycles after accept.
REQ-034 All four requesters valid continuously -> grant order 0, 1, 2, 3, 0; no requester granted twice in any window of 4 grants.
REQ-035 Backpressure: rsp_ready[1] held low for 20 cycles -> rsp_valid[1] and rsp_product stable; req_ready stays all zero throughout.
REQ-036 Timeout: mult_done never arrives, TIMEOUT=64 -> rsp_valid with rsp_product=0 and rsp_err=1, 64 cycles after entering WAIT.
REQ-037 Spurious mult_done pulse in IDLE and in START -> no state change, no rsp_valid.
REQ-038 reset_n pulsed low during WAIT -> all outputs 0 immediately; the next grant after reset goes to the lowest-index valid requester.
